// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register for the 5-stage RV32I core.
// Fetches over a variable-latency req/valid imem port, absorbs stalls, redirects on EX branches.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  // state   | meaning
  // S_FETCH | request outstanding at PCF
  // S_HOLD  | no request, fetched word parked in buffer until stall releases
  // S_DROP  | request at stale address still open, its response is discarded
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  logic        stall;
  logic        word_vld;
  logic [31:0] word_instr;
  logic [31:0] word_pc;

  assign stall     = StallF | StallD;
  assign imem_req  = rst && (state_q != S_HOLD);
  assign imem_addr = (state_q == S_DROP) ? drop_addr_q : pcf_q;

  always_comb begin
    state_d     = state_q;
    pcf_d       = pcf_q;
    drop_addr_d = drop_addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    word_vld    = 1'b0;
    word_instr  = imem_rdata;
    word_pc     = pcf_q;
    case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          if (PCSrcE) begin
            pcf_d = PCTargetE;
          end else if (!stall) begin
            word_vld = 1'b1;
            pcf_d    = pcf_q + 32'd4;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = pcf_q;
            state_d     = S_HOLD;
          end
        end else if (PCSrcE) begin
          drop_addr_d = pcf_q;
          pcf_d       = PCTargetE;
          state_d     = S_DROP;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pcf_d   = PCTargetE;
          state_d = S_FETCH;
        end else if (!stall) begin
          word_vld   = 1'b1;
          word_instr = buf_instr_q;
          word_pc    = buf_pc_q;
          pcf_d      = pcf_q + 32'd4;
          state_d    = S_FETCH;
        end
      end
      S_DROP: begin
        // latest redirect wins even while the stale response is pending
        if (PCSrcE) pcf_d = PCTargetE;
        if (imem_valid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instr_d   = instr_q;
    pcd_d     = pcd_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (FlushD) begin
      instr_d   = NOP_INSTR;
      pcd_d     = 32'd0;
      pcplus4_d = 32'd0;
      valid_d   = 1'b0;
    end else if (StallD) begin
      valid_d = valid_q;
    end else if (word_vld) begin
      instr_d   = word_instr;
      pcd_d     = word_pc;
      pcplus4_d = word_pc + 32'd4;
      valid_d   = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      pcf_q       <= RESET_PC;
      drop_addr_q <= 32'd0;
      buf_instr_q <= 32'd0;
      buf_pc_q    <= 32'd0;
      instr_q     <= NOP_INSTR;
      pcd_q       <= 32'd0;
      pcplus4_q   <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcf_q       <= pcf_d;
      drop_addr_q <= drop_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      instr_q     <= instr_d;
      pcd_q       <= pcd_d;
      pcplus4_q   <= pcplus4_d;
      valid_q     <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcplus4_q;
  assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a latency-programmable imem model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int          tests = 0;
  int          fails = 0;
  int          lat   = 0;
  int          wait_cnt;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  // imem responds lat cycles after the request rises; word = addr | 0x13
  always @(posedge clk) begin
    if (!imem_req || imem_valid) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign imem_valid = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_addr | 32'h13;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 32'h0;
    tick(); tick();
  endtask

  task automatic test_reset();
    lat = 0;
    do_reset();
    tests++; if (InstrD !== 32'h13) begin fails++; $display("FAIL reset_instr actual=%h expected=%h", InstrD, 32'h13); end
    tests++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin fails++; $display("FAIL reset_pc actual=%h/%h expected=0/0", PCD, PCPlus4D); end
    tests++; if (ValidD !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL reset_valid_req actual=%b/%b expected=0/0", ValidD, imem_req); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (PCD !== 32'(4*i) || InstrD !== (32'(4*i) | 32'h13) || PCPlus4D !== 32'(4*i+4) || ValidD !== 1'b1) begin
        fails++;
        $display("FAIL zero_wait_%0d actual pcd=%h instr=%h p4=%h v=%b expected pcd=%h", i, PCD, InstrD, PCPlus4D, ValidD, 32'(4*i));
      end
    end
  endtask

  task automatic test_latency();
    lat = 3;
    do_reset();
    rst = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL lat_first_req actual=%b/%h expected=1/0", imem_req, imem_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (imem_addr !== 32'h0 || ValidD !== 1'b0 || imem_req !== 1'b1) begin
        fails++; $display("FAIL lat_wait_%0d actual addr=%h v=%b expected addr=0 v=0", i, imem_addr, ValidD);
      end
    end
    tick();
    tests++; if (ValidD !== 1'b1 || PCD !== 32'h0 || InstrD !== 32'h13) begin fails++; $display("FAIL lat_deliver actual v=%b pcd=%h instr=%h expected 1/0/13", ValidD, PCD, InstrD); end
    tick();
    tests++; if (ValidD !== 1'b0 || imem_addr !== 32'h4) begin fails++; $display("FAIL lat_once actual v=%b addr=%h expected 0/4", ValidD, imem_addr); end
  endtask

  task automatic test_stall();
    lat = 0;
    do_reset();
    rst = 1'b1;
    tick(); tick();
    StallF = 1; StallD = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (PCD !== 32'h4 || InstrD !== 32'h17 || imem_req !== 1'b0) begin
        fails++; $display("FAIL stall_hold_%0d actual pcd=%h instr=%h req=%b expected 4/17/0", i, PCD, InstrD, imem_req);
      end
    end
    StallF = 0; StallD = 0;
    tick();
    tests++; if (PCD !== 32'h8 || InstrD !== 32'h1B || ValidD !== 1'b1) begin fails++; $display("FAIL stall_release actual pcd=%h instr=%h v=%b expected 8/1b/1", PCD, InstrD, ValidD); end
    tick();
    tests++; if (PCD !== 32'hC || ValidD !== 1'b1) begin fails++; $display("FAIL stall_next actual pcd=%h v=%b expected c/1", PCD, ValidD); end
  endtask

  task automatic test_redirect_drop();
    lat = 0;
    do_reset();
    rst = 1'b1;
    tick(); tick(); tick(); tick();
    lat = 2;
    PCSrcE = 1; PCTargetE = 32'h100; FlushD = 1;
    tick();
    PCSrcE = 0; FlushD = 0;
    tests++; if (imem_addr !== 32'h10 || imem_req !== 1'b1 || ValidD !== 1'b0 || InstrD !== 32'h13 || PCD !== 32'h0) begin
      fails++; $display("FAIL drop_enter actual addr=%h req=%b v=%b instr=%h pcd=%h expected 10/1/0/13/0", imem_addr, imem_req, ValidD, InstrD, PCD); end
    tick();
    tests++; if (imem_addr !== 32'h10 || imem_valid !== 1'b1) begin fails++; $display("FAIL drop_resp actual addr=%h vld=%b expected 10/1", imem_addr, imem_valid); end
    tick();
    tests++; if (imem_addr !== 32'h100 || ValidD !== 1'b0) begin fails++; $display("FAIL drop_target actual addr=%h v=%b expected 100/0", imem_addr, ValidD); end
    tick(); tick(); tick();
    tests++; if (PCD !== 32'h100 || InstrD !== 32'h113 || ValidD !== 1'b1) begin fails++; $display("FAIL drop_fetch actual pcd=%h instr=%h v=%b expected 100/113/1", PCD, InstrD, ValidD); end
  endtask

  task automatic test_redirect_hold();
    lat = 0;
    do_reset();
    rst = 1'b1;
    PCSrcE = 1; PCTargetE = 32'h200;
    tick();
    PCSrcE = 0;
    tests++; if (ValidD !== 1'b0 || imem_addr !== 32'h200) begin fails++; $display("FAIL redir_same actual v=%b addr=%h expected 0/200", ValidD, imem_addr); end
    StallF = 1; StallD = 1;
    tick();
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL redir_hold_req actual=%b expected=0", imem_req); end
    PCSrcE = 1; PCTargetE = 32'h300;
    tick();
    PCSrcE = 0; StallF = 0; StallD = 0;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || ValidD !== 1'b0) begin fails++; $display("FAIL redir_hold_tgt actual req=%b addr=%h v=%b expected 1/300/0", imem_req, imem_addr, ValidD); end
    tick();
    tests++; if (PCD !== 32'h300 || InstrD !== 32'h313 || ValidD !== 1'b1) begin fails++; $display("FAIL redir_hold_fetch actual pcd=%h instr=%h v=%b expected 300/313/1", PCD, InstrD, ValidD); end
  endtask

  task automatic test_reset_drop_wrap();
    lat = 5;
    do_reset();
    rst = 1'b1;
    PCSrcE = 1; PCTargetE = 32'hFFFF_FFFC;
    tick();
    PCSrcE = 0;
    tests++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin fails++; $display("FAIL wrap_drop actual addr=%h req=%b expected 0/1", imem_addr, imem_req); end
    rst = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL wrap_rst_req actual=%b expected=0", imem_req); end
    tick();
    tests++; if (InstrD !== 32'h13 || PCD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0 || imem_req !== 1'b0) begin
      fails++; $display("FAIL wrap_rst_out actual instr=%h pcd=%h p4=%h v=%b req=%b", InstrD, PCD, PCPlus4D, ValidD, imem_req); end
    lat = 0;
    rst = 1'b1; PCSrcE = 1; PCTargetE = 32'hFFFF_FFFC;
    #1;
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_restart actual addr=%h expected=0", imem_addr); end
    tick();
    PCSrcE = 0;
    tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr actual=%h expected=fffffffc", imem_addr); end
    tick();
    tests++; if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || InstrD !== 32'hFFFF_FFFF || ValidD !== 1'b1) begin
      fails++; $display("FAIL wrap_p4 actual pcd=%h p4=%h instr=%h v=%b expected fffffffc/0/ffffffff/1", PCD, PCPlus4D, InstrD, ValidD); end
    tick();
    tests++; if (PCD !== 32'h0 || InstrD !== 32'h13 || PCPlus4D !== 32'h4) begin fails++; $display("FAIL wrap_next actual pcd=%h instr=%h p4=%h expected 0/13/4", PCD, InstrD, PCPlus4D); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cnt = 0;
    test_reset();
    test_latency();
    test_stall();
    test_redirect_drop();
    test_redirect_hold();
    test_reset_drop_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
